// File: rtl/layer_stream_pkg.sv
// Shared types and sizing helpers for the inter-layer stream transmitter.
// Optional zero-pad build: define LAYER_STREAM_TX_ZERO_PAD_EN.
package layer_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_CHANNELS  = 256;
    localparam int DEF_IMG_DIM   = 13;
    localparam int DEF_PAD       = 1;

    function automatic int padded_dim(input int dim, input int pad);
        return dim + 2 * pad;
    endfunction

    function automatic int npix(input int dim, input int pad);
        return padded_dim(dim, pad) * padded_dim(dim, pad);
    endfunction

    // Index width for n entries, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_stream_tx_if.sv
// Write-side and stream-side signals of the inter-layer channel.
// The transmitter connects through the slave modport; the driver/sink through master.
interface layer_stream_tx_if #(
    parameter int DATA_SIZE = 8,
    parameter int CHANNELS  = 256,
    parameter int IMG_DIM   = 13
);
    localparam int AW = (IMG_DIM * IMG_DIM > 1) ? $clog2(IMG_DIM * IMG_DIM) : 1;

    logic                                i_wr_en;
    logic [AW-1:0]                       i_wr_addr;
    logic [CHANNELS-1:0][DATA_SIZE-1:0]  i_wr_data;
    logic                                i_start;
    logic                                o_ready;
    logic                                i_next_ready;
    logic [CHANNELS-1:0][DATA_SIZE-1:0]  o_next_data;
    logic [CHANNELS-1:0]                 o_next_we;
    logic                                o_next_start;

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_next_ready,
        output o_ready, o_next_data, o_next_we, o_next_start
    );

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_start, i_next_ready,
        input  o_ready, o_next_data, o_next_we, o_next_start
    );

endinterface

// File: rtl/layer_stream_tx_raster_counter.sv
// Row/col raster position over a DIM x DIM frame with last-pixel and pad-border flags.
// Border flag is only built when PAD > 0 (LAYER_STREAM_TX_ZERO_PAD_EN builds).
module raster_counter #(
    parameter int DIM = 3,
    parameter int PAD = 0,
    parameter int RW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [RW-1:0] row_o,
    output logic [RW-1:0] col_o,
    output logic          last_o,
    output logic          border_o
);

    logic [RW-1:0] row_q, row_d;
    logic [RW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_q == RW'(DIM - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(DIM - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == RW'(DIM - 1)) && (col_q == RW'(DIM - 1));

    generate
        if (PAD > 0) begin : g_border
            assign border_o = (row_q < RW'(PAD)) || (row_q > RW'(DIM - 1 - PAD)) ||
                              (col_q < RW'(PAD)) || (col_q > RW'(DIM - 1 - PAD));
        end else begin : g_no_border
            assign border_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/layer_stream_tx.sv
// Buffers one IMG_DIM x IMG_DIM feature map and streams it in raster order, then pulses o_next_start.
// Define LAYER_STREAM_TX_ZERO_PAD_EN to stream a zero-bordered (IMG_DIM+2*PAD)^2 frame.
module layer_stream_tx
    import layer_stream_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int IMG_DIM   = DEF_IMG_DIM,
    parameter int PAD       = DEF_PAD
) (
    input  logic              clk,
    input  logic              rst,
    layer_stream_tx_if.slave  bus
);

`ifdef LAYER_STREAM_TX_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int PADW  = PAD_EN ? PAD : 0;
    localparam int DIM_P = padded_dim(IMG_DIM, PADW);
    localparam int NRAW  = IMG_DIM * IMG_DIM;
    localparam int AW    = idx_w(NRAW);
    localparam int RW    = idx_w(DIM_P);

    typedef logic [CHANNELS-1:0][DATA_SIZE-1:0] pix_t;

    state_e              state_q;
    logic                ready_q;
    logic                start_q;
    logic [CHANNELS-1:0] we_q;
    pix_t                data_q;

    // Buffer is deliberately left out of reset.
    pix_t                mem [NRAW];
    logic                wr_ok;
    logic [AW-1:0]       rd_addr;
    pix_t                rd_data;

    logic [RW-1:0]       row, col;
    logic                last, border;
    logic                beat;

    assign beat  = (state_q == STREAM) && bus.i_next_ready;
    assign wr_ok = (state_q == IDLE) && bus.i_wr_en && (32'(bus.i_wr_addr) < 32'(NRAW));

    raster_counter #(
        .DIM (DIM_P),
        .PAD (PADW),
        .RW  (RW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == IDLE),
        .en_i     (beat),
        .row_o    (row),
        .col_o    (col),
        .last_o   (last),
        .border_o (border)
    );

    // Padded coordinates map back onto the unpadded buffer; border beats never read it.
    always_comb begin
        rd_addr = '0;
        if (!border)
            rd_addr = AW'((32'(row) - 32'(PADW)) * 32'(IMG_DIM) + 32'(col) - 32'(PADW));
        rd_data = border ? '0 : mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[bus.i_wr_addr] <= bus.i_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            start_q <= 1'b0;
            we_q    <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    start_q <= 1'b0;
                    we_q    <= '0;
                    if (bus.i_start) begin
                        state_q <= STREAM;
                        ready_q <= 1'b0;
                    end
                end
                STREAM: begin
                    if (bus.i_next_ready) begin
                        data_q <= rd_data;
                        we_q   <= '1;
                        if (last)
                            state_q <= DONE;
                    end else begin
                        we_q <= '0;
                    end
                end
                DONE: begin
                    // Last beat is on the bus this cycle; the frame-end pulse follows it.
                    we_q    <= '0;
                    start_q <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    we_q    <= '0;
                end
            endcase
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_next_data  = data_q;
    assign bus.o_next_we    = we_q;
    assign bus.o_next_start = start_q;

endmodule
